// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access widths and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_FAULT
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and
// misaligned/illegal detection for one access.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            fault_o
);

    logic [XLEN-1:0] sh;
    logic            illegal;
    logic            misaligned;

    always_comb begin
        be_o       = '0;
        wdata_o    = '0;
        rdata_o    = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        sh         = mem_rdata_i >> {off_i, 3'b000};

        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misaligned = off_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                misaligned = (off_i != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

        // Unsigned variants exist only for loads.
        if (is_store_i && funct3_i[2])
            illegal = 1'b1;

        case (funct3_i)
            F3_B:    rdata_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_H:    rdata_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: rdata_o = mem_rdata_i;
        endcase

        fault_o = illegal | misaligned;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM: latches the access on start, holds a request/ack
// memory transaction, and reports done/fault to the core.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            sel_store;
    logic [2:0]      sel_f3;
    logic [1:0]      sel_off;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_fault;

    // One aligner serves both the IDLE fault check (live inputs) and ACCESS (latched).
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_store = is_store;
            sel_f3    = funct3;
            sel_off   = addr[1:0];
        end else begin
            sel_store = store_q;
            sel_f3    = f3_q;
            sel_off   = addr_q[1:0];
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .is_store_i  (sel_store),
        .funct3_i    (sel_f3),
        .off_i       (sel_off),
        .wdata_i     (wdata_q),
        .mem_rdata_i (mem_rdata),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata),
        .fault_o     (al_fault)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        store_d = store_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    f3_d    = funct3;
                    store_d = is_store;
                    state_d = al_fault ? ST_FAULT : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    if (!store_q)
                        rdata_d = al_rdata;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE) || (state_q == ST_FAULT);
        fault     = (state_q == ST_FAULT);
        mem_req   = (state_q == ST_ACCESS);
        mem_we    = mem_req && store_q;
        mem_addr  = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        mem_be    = mem_req ? al_be : '0;
        mem_wdata = mem_req ? al_wdata : '0;
        rdata     = rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses against
// an arithmetic reference model of the byte-lane rules.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: access size from funct3, lanes from address offset, plain arithmetic.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] md,
                                  output bit flt, output logic [3:0] be,
                                  output logic [31:0] wrep, output logic [31:0] ld);
        int unsigned size;
        int unsigned o;
        bit          legal;
        longint      v;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            default: size = 4;
        endcase
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        o    = a % 4;
        flt  = !legal || ((a % size) != 0);
        be   = 4'(((1 << size) - 1) << o);
        if (size == 1)      wrep = 32'(wd % 256) * 32'h0101_0101;
        else if (size == 2) wrep = 32'(wd % 65536) * 32'h0001_0001;
        else                wrep = wd;
        v = longint'(md) / (longint'(1) << (8 * o));
        if (size < 4) begin
            v = v % (longint'(1) << (8 * size));
            if (f3[2] == 1'b0 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
        end
        ld = 32'(v);
    endfunction

    task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] md, input int unsigned waits);
        bit          flt;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] ld;
        model(st, f3, a, wd, md, flt, be, wrep, ld);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        // Core keeps start high; scramble the operands to show they were latched.
        is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        check("busy_after_start", 32'(busy), 32'd1);
        if (flt) begin
            check("fault_done", 32'(done), 32'd1);
            check("fault_flag", 32'(fault), 32'd1);
            check("fault_no_req", 32'(mem_req), 32'd0);
        end else begin
            check("req", 32'(mem_req), 32'd1);
            check("we", 32'(mem_we), 32'(st));
            check("addr", mem_addr, {a[31:2], 2'b00});
            check("be", 32'(mem_be), 32'(be));
            if (st) check("wdata", mem_wdata, wrep);
            check("no_early_done", 32'(done), 32'd0);
            for (int unsigned i = 0; i < waits; i++) begin
                mem_ack = 1'b0; mem_rdata = $urandom;
                @(posedge clk); #1;
                check("req_hold", 32'(mem_req), 32'd1);
                check("addr_hold", mem_addr, {a[31:2], 2'b00});
                check("be_hold", 32'(mem_be), 32'(be));
                if (st) check("wdata_hold", mem_wdata, wrep);
                check("wait_no_done", 32'(done), 32'd0);
            end
            mem_ack = 1'b1; mem_rdata = md;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (!st) exp_rdata = ld;
            check("done", 32'(done), 32'd1);
            check("done_no_fault", 32'(fault), 32'd0);
            check("done_req_low", 32'(mem_req), 32'd0);
        end
        check("rdata", rdata, exp_rdata);
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; exp_rdata = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        run(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
        run(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
        run(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3);
        run(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111, 0);
        run(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h2222_2222, 0);

        // Reset in the middle of an access; start stays high throughout.
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_be", 32'(mem_be), 32'd0);
        check("arst_maddr", mem_addr, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        exp_rdata = '0;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stray_ack_done", 32'(done), 32'd0);
            check("stray_ack_busy", 32'(busy), 32'd0);
            check("stray_ack_rdata", rdata, exp_rdata);
        end
        mem_ack = 1'b0;
        run(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0);

        for (int n = 0; n < 200; n++) begin
            logic [2:0]  f3r;
            logic [31:0] ar;
            f3r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3r = 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
            ar = $urandom;
            run(1'($urandom), f3r, ar, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle core's memory stage: consumes the ALU `Result` as the effective address, drives a request/acknowledge data-memory port with word-aligned address, byte enables and lane-replicated store data, and returns sign- or zero-extended load data. It stalls the core via `busy` until memory acknowledges, and flags misaligned or illegal accesses without touching memory.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: access request from the core; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `addr` in 32: effective address, the ALU `Result`.
- `wdata` in 32: store data (rs2).
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: one-cycle pulse with `done` on a misaligned or illegal access.
- `rdata` out 32: extended load data; holds until the next load completes.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory accepted the access; read data valid in the same cycle.
- `mem_rdata` in 32: read data.

## Operation
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE with `start`=1:
  - `addr`, `wdata`, `funct3` and `is_store` are registered.
  - Illegal encoding (load 011/110/111, any store with 1xx/011) → FAULT.
  - Misaligned (halfword with `addr[0]`=1, word with `addr[1:0]`≠0) → FAULT.
  - Otherwise → ACCESS.
- `start` in any non-IDLE state is ignored; the core holds it until `done`.
- ACCESS:
  - `mem_req`=1; `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` stay stable until `mem_ack`.
  - On `mem_ack`, the load result is captured into `rdata` and the state moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- FAULT: `done`=1 and `fault`=1 for one cycle, then IDLE. No memory request; `rdata` is unchanged.
- Byte enables, with `o` = `addr[1:0]`:
  - byte: `4'b0001<<o`
  - half: `4'b0011<<o`
  - word: `4'b1111`
  - Loads drive the same enables with `mem_we`=0.
- Store data: byte → `{4{wdata[7:0]}}`, half → `{2{wdata[15:0]}}`, word → `wdata`.
- Load data: `sh = mem_rdata >> (8*o)`.
  - LB/LH sign-extend `sh[7:0]`/`sh[15:0]`; LBU/LHU zero-extend.
  - LW passes `mem_rdata` through.
- Stores leave `rdata` unchanged.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset (asynchronous): state IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we` are 0; `mem_addr`, `mem_be`, `mem_wdata`, `rdata` are 0.
- `start` is sampled at edge N; `mem_req` rises after edge N.
- Earliest `mem_ack` is the first cycle `mem_req` is high (ack sampled at edge N+1); `done` is high in the cycle after edge N+1.
  - Minimum latency: 2 cycles from the `start` edge to `done`.
  - Each wait cycle adds 1.
- Fault path: `done`/`fault` are high in the cycle after the `start` edge (1 cycle).
- `busy` is high from the cycle after the `start` edge through the DONE/FAULT cycle inclusive.
- A new `start` is accepted in the cycle after DONE or FAULT (back-to-back issue every 3 cycles with zero-wait memory).
- `rst` asserted mid-ACCESS drops `mem_req` immediately. The access is abandoned and produces no `done`.

## Structure
- `lsu_pkg`: `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state typedef `lsu_state_t`.
- Sub-module `lsu_align` (combinational) provides:
  - byte-enable generation;
  - store-data replication;
  - load shift and extension;
  - misaligned/illegal detection.
- The top level contains only the FSM and registers.

## Test plan
- LW, `addr`=0x100, `mem_rdata`=0xDEADBEEF, zero-wait ack → `mem_addr`=0x100, `mem_be`=1111; `done` 2 cycles after `start`; `rdata`=0xDEADBEEF.
- LB, `addr`=0x103, `mem_rdata`=0x80000000 → `mem_be`=1000; `rdata`=0xFFFFFF80. LBU at the same address → `rdata`=0x00000080.
- SH, `addr`=0x202, `wdata`=0x1234ABCD, `mem_ack` delayed 3 cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD; request stable for 4 cycles; `done` after 5.
- LW at `addr`=0x101, and separately `funct3`=011 → `done` and `fault` both high 1 cycle after `start`; `mem_req` never asserts; `rdata` unchanged.
- `start` pulsed while in ACCESS, then `rst` asserted mid-ACCESS → second start ignored; `mem_req` drops asynchronously; all outputs 0; no `done`.
- `mem_ack` held high in IDLE, then an LHU at 0x002 with `mem_rdata`=0xF00D0000 → stray ack ignored; `rdata`=0x0000F00D.
